issue_scoreboard: RTL and testbench

Parametrised scoreboard and issue controller for the Apogeo front end. It sits between decode and the execution units and tracks four things: pending destination registers, per-unit busy time for non-pipelined units, future writeback-slot occupancy, and reorder-buffer occupancy. It generalises the fixed-unit scheduler to `NUM_UNITS` units with per-instruction latency, writeback-port conflict detection and ROB-full back-pressure. Each cycle it decides whether the instruction presented by decode issues, and it supplies that instruction's ROB tag.

---
 rtl/apogeo_pkg.sv | 16 +
 rtl/writeback_slot_tracker.sv | 38 +++
 rtl/issue_scoreboard.sv | 114 +++++++++++
 tb/tb_issue_scoreboard.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apogeo_pkg.sv
// Shared Apogeo front-end definitions: ROB tag type, unit index map and the
// default pipelined-unit mask.
package apogeo_pkg;

   localparam int APOGEO_ROB_DEPTH = 32;
   typedef logic [$clog2(APOGEO_ROB_DEPTH)-1:0] rob_tag_t;

   localparam int UNIT_ALU = 0;
   localparam int UNIT_MUL = 1;
   localparam int UNIT_DIV = 2;
   localparam int UNIT_LSU = 3;

   // ALU and MUL accept one instruction per cycle; DIV and LSU do not.
   localparam logic [3:0] UNIT_PIPELINED_DEFAULT = 4'b0011;

endpackage

// File: rtl/writeback_slot_tracker.sv
// Future writeback-port occupancy: slot[k] set means a result lands k cycles
// from now. Flags a new instruction whose writeback would collide.
module writeback_slot_tracker #(
   parameter int MAX_LATENCY = 8,
   parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             issue,
   input  logic [LAT_W-1:0] latency,
   output logic             conflict,
   output logic             empty
);

   logic [MAX_LATENCY:1] slot;
   logic [MAX_LATENCY:1] slot_nxt;

   always_comb begin
      conflict = 1'b0;
      for (int k = 1; k <= MAX_LATENCY; k++)
         if (int'(latency) == k) conflict = slot[k];
   end

   // Shift toward slot 1; a latency-L issue lands in slot L-1 next cycle.
   always_comb begin
      slot_nxt = '0;
      for (int k = 1; k < MAX_LATENCY; k++)
         slot_nxt[k] = slot[k+1] | (issue && int'(latency) == k + 1);
   end

   always_ff @(posedge clk) begin
      if (clear) slot <= '0;
      else       slot <= slot_nxt;
   end

   assign empty = ~|slot;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: tracks pending registers, unit busy time, writeback slots
// and ROB occupancy, and decides each cycle whether decode's instruction issues.
module issue_scoreboard
   import apogeo_pkg::*;
#(
   parameter int                   ROB_DEPTH      = 32,
   parameter int                   NUM_UNITS      = 4,
   parameter int                   MAX_LATENCY    = 8,
   parameter logic [NUM_UNITS-1:0] UNIT_PIPELINED = UNIT_PIPELINED_DEFAULT
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 flush_i,
   input  logic                                 stall_i,
   input  logic                                 valid_i,
   input  logic [NUM_UNITS-1:0]                 unit_i,
   input  logic [$clog2(MAX_LATENCY+1)-1:0]     latency_i,
   input  logic [1:0][4:0]                      src_reg_i,
   input  logic [1:0]                           src_valid_i,
   input  logic [4:0]                           dest_reg_i,
   input  logic                                 fence_i,
   input  logic                                 writeback_i,
   input  logic [4:0]                           writeback_reg_i,
   input  logic                                 rob_retire_i,
   output logic                                 issue_o,
   output logic                                 stall_o,
   output logic [$clog2(ROB_DEPTH)-1:0]         rob_tag_o,
   output logic                                 rob_full_o,
   output logic                                 pipeline_empty_o
);

   localparam int LAT_W = $clog2(MAX_LATENCY + 1);
   localparam int TAG_W = $clog2(ROB_DEPTH);
   localparam int OCC_W = TAG_W + 1;

   logic [31:0]          pending;
   logic [31:0]          pending_nxt;
   logic [LAT_W-1:0]     busy [NUM_UNITS];
   logic [NUM_UNITS-1:0] unit_busy;
   logic [OCC_W-1:0]     occ;
   logic [LAT_W-1:0]     lat;
   logic                 raw, waw, structural, slot_conflict, slots_empty;
   logic                 fence_block, hazard, clear, issue;

   assign lat   = (latency_i == '0) ? LAT_W'(1) : latency_i;
   assign clear = rst_i | flush_i;

   // A source being written back this cycle is forwarded, so it is not a hazard.
   always_comb begin
      raw = 1'b0;
      for (int i = 0; i < 2; i++)
         if (src_valid_i[i] && pending[src_reg_i[i]] &&
             !(writeback_i && writeback_reg_i == src_reg_i[i]))
            raw = 1'b1;
   end

   assign waw        = (dest_reg_i != 5'd0) && pending[dest_reg_i];
   assign structural = |(unit_i & ~UNIT_PIPELINED & unit_busy);

   assign rob_full_o       = (occ == OCC_W'(ROB_DEPTH));
   assign pipeline_empty_o = (pending == '0) && slots_empty && (unit_busy == '0);
   assign fence_block      = fence_i && !pipeline_empty_o;

   assign hazard  = raw | waw | structural | slot_conflict | rob_full_o | fence_block;
   assign issue   = valid_i & ~stall_i & ~hazard & ~clear;
   assign issue_o = issue;
   assign stall_o = valid_i & hazard;

   // Set after clear so a same-cycle issue to the written-back register wins.
   always_comb begin
      pending_nxt = pending;
      if (writeback_i) pending_nxt[writeback_reg_i] = 1'b0;
      if (issue && dest_reg_i != 5'd0) pending_nxt[dest_reg_i] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         pending   <= '0;
         occ       <= '0;
         rob_tag_o <= '0;
      end else begin
         pending   <= pending_nxt;
         rob_tag_o <= rob_tag_o + TAG_W'(issue);
         if (issue && !rob_retire_i)
            occ <= occ + OCC_W'(1);
         else if (!issue && rob_retire_i && occ != '0)
            occ <= occ - OCC_W'(1);
      end
   end

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
      assign unit_busy[u] = (busy[u] != '0);

      always_ff @(posedge clk_i) begin
         if (clear)                   busy[u] <= '0;
         else if (issue && unit_i[u]) busy[u] <= lat;
         else if (unit_busy[u])       busy[u] <= busy[u] - LAT_W'(1);
      end
   end

   writeback_slot_tracker #(
      .MAX_LATENCY (MAX_LATENCY),
      .LAT_W       (LAT_W)
   ) u_slots (
      .clk      (clk_i),
      .clear    (clear),
      .issue    (issue),
      .latency  (lat),
      .conflict (slot_conflict),
      .empty    (slots_empty)
   );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic, all
// checked every cycle against a time-stamp based reference model.
module tb_issue_scoreboard;

   localparam int RD = 4;
   localparam logic [3:0] PIPE = 4'b0011;

   logic       clk = 1'b0;
   logic       rst, flush, dstall, valid, fence, wb, retire;
   logic [3:0] unit, lat;
   logic [1:0][4:0] src;
   logic [1:0] srcv;
   logic [4:0] dest, wbreg;
   logic       issue, stall, full, empty;
   logic [1:0] tag;

   always #5 clk = ~clk;

   issue_scoreboard #(
      .ROB_DEPTH (RD), .NUM_UNITS (4), .MAX_LATENCY (8), .UNIT_PIPELINED (PIPE)
   ) dut (
      .clk_i (clk), .rst_i (rst), .flush_i (flush), .stall_i (dstall),
      .valid_i (valid), .unit_i (unit), .latency_i (lat), .src_reg_i (src),
      .src_valid_i (srcv), .dest_reg_i (dest), .fence_i (fence),
      .writeback_i (wb), .writeback_reg_i (wbreg), .rob_retire_i (retire),
      .issue_o (issue), .stall_o (stall), .rob_tag_o (tag),
      .rob_full_o (full), .pipeline_empty_o (empty)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: absolute cycle times instead of counters/shift registers.
   typedef struct { int t; logic [4:0] r; } wbev_t;
   bit    m_pend [32];
   int    m_free_at [4];   // unit is busy while cyc < m_free_at
   int    m_wbt [$];       // absolute writeback times reserved
   wbev_t m_sched [$];     // writebacks the bench will strobe
   int    m_occ = 0, m_tag = 0, cyc = 0;
   bit    m_issue;
   bit    chk_en = 1'b0, auto_ret = 1'b0;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         n_assert++;
         assert ($onehot(unit))
         else begin
            n_fail++;
            $error("FAIL unit_onehot: observed %b expected one-hot", unit);
         end
      end
   end

   function automatic bit model_empty();
      bit e = 1'b1;
      foreach (m_pend[i]) if (m_pend[i]) e = 1'b0;
      foreach (m_wbt[i]) if (m_wbt[i] > cyc) e = 1'b0;
      for (int k = 0; k < 4; k++) if (m_free_at[k] > cyc) e = 1'b0;
      return e;
   endfunction

   task automatic model_clear();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_free_at[k] = 0;
      m_wbt.delete();
      m_sched.delete();
      m_occ = 0;
      m_tag = 0;
   endtask

   // One clock: drive automatic strobes, check at negedge, advance model at posedge.
   task automatic tick(input int ei = -1, input int es = -1, input int ee = -1,
                       input int et = -1, input int ef = -1);
      int  L, u;
      bit  raw, waw, st, sl, emp, hz, m_stall;
      int  keep [$];
      if (auto_ret) retire = (m_occ > 0);
      wb = 1'b0; wbreg = 5'd0;
      foreach (m_sched[i]) if (m_sched[i].t == cyc) begin wb = 1'b1; wbreg = m_sched[i].r; end
      @(negedge clk);
      L = (lat == 4'd0) ? 1 : int'(lat);
      u = 0;
      for (int k = 0; k < 4; k++) if (unit[k]) u = k;
      raw = 1'b0;
      for (int i = 0; i < 2; i++)
         if (srcv[i] && m_pend[src[i]] && !(wb && wbreg == src[i])) raw = 1'b1;
      waw = (dest != 5'd0) && m_pend[dest];
      st  = !PIPE[u] && (cyc < m_free_at[u]);
      sl  = 1'b0;
      foreach (m_wbt[i]) if (m_wbt[i] == cyc + L) sl = 1'b1;
      emp = model_empty();
      hz  = raw | waw | st | sl | (m_occ == RD) | (fence && !emp);
      m_issue = valid && !dstall && !hz && !flush && !rst;
      m_stall = valid && hz;
      if (chk_en) begin
         chk("issue",  issue, m_issue);
         chk("stall",  stall, m_stall);
         chk("tag",    tag,   m_tag);
         chk("full",   full,  m_occ == RD);
         chk("empty",  empty, emp);
      end
      if (ei >= 0) chk("dir_issue", issue, ei);
      if (es >= 0) chk("dir_stall", stall, es);
      if (ee >= 0) chk("dir_empty", empty, ee);
      if (et >= 0) chk("dir_tag",   tag,   et);
      if (ef >= 0) chk("dir_full",  full,  ef);
      @(posedge clk);
      if (rst || flush) model_clear();
      else begin
         if (wb) m_pend[wbreg] = 1'b0;
         if (m_issue) begin
            if (dest != 5'd0) begin
               m_pend[dest] = 1'b1;
               m_sched.push_back('{cyc + L, dest});
            end
            m_free_at[u] = cyc + L + 1;
            m_wbt.push_back(cyc + L);
            m_tag = (m_tag + 1) % RD;
         end
         if (m_issue && !retire) m_occ++;
         else if (!m_issue && retire && m_occ > 0) m_occ--;
      end
      cyc++;
      foreach (m_wbt[i]) if (m_wbt[i] >= cyc) keep.push_back(m_wbt[i]);
      m_wbt = keep;
      #1;
   endtask

   task automatic idle();
      valid = 1'b0; fence = 1'b0; flush = 1'b0; rst = 1'b0; dstall = 1'b0;
      srcv = 2'b00; src = '0; dest = 5'd0; unit = 4'b0001; lat = 4'd1;
   endtask

   task automatic present(input int u, input int l, input int d,
                          input int s0 = 0, input int s0v = 0, input int fen = 0);
      valid = 1'b1; unit = 4'b0001 << u; lat = 4'(l); dest = 5'(d);
      src[0] = 5'(s0); src[1] = 5'd0; srcv = {1'b0, s0v[0]}; fence = fen[0];
   endtask

   task automatic drain(input int n);
      idle();
      repeat (n) tick();
   endtask

   initial begin
      int age;
      idle();
      retire = 1'b0;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      rst = 1'b0;
      // Reset state, then a retire at occupancy 0 that must be ignored.
      tick(0, 0, 1, 0, 0);
      retire = 1'b1;
      tick(0, 0, 1, 0, 0);
      retire = 1'b0;

      // ROB full and tag wrap.
      for (int i = 0; i < 4; i++) begin
         present(0, 1, 0);
         tick(1, 0, -1, i, 0);
      end
      present(0, 1, 0);
      tick(0, 1, -1, 0, 1);
      retire = 1'b1;
      tick(0, 1, -1, 0, 1);
      retire = 1'b0;
      tick(1, 0, -1, 0, 0);
      auto_ret = 1'b1;
      drain(10);

      // Back-to-back RAW: issues in the cycle x5 is written back.
      present(0, 3, 5);
      tick(1);
      present(0, 1, 6, 5, 1);
      tick(0, 1); tick(0, 1); tick(1, 0);
      drain(6);

      // Non-pipelined DIV busy for L=4, second op presented one cycle later.
      present(2, 4, 0);
      tick(1);
      idle(); tick();
      present(2, 1, 0);
      tick(0, 1); tick(0, 1); tick(0, 1); tick(1, 0);
      drain(6);

      // Writeback-slot conflict.
      present(0, 4, 0);
      tick(1);
      idle(); tick();
      present(1, 2, 0);
      tick(0, 1); tick(1, 0);
      drain(8);

      // Fence behind an L=2 op issued together with a retire.
      auto_ret = 1'b0; retire = 1'b0;
      present(1, 1, 0);
      tick(1);
      present(0, 2, 7);
      retire = 1'b1;
      tick(1);
      retire = 1'b0;
      present(0, 1, 0, 0, 0, 1);
      tick(0, 1, 0); tick(0, 1, 0); tick(1, 0, 1);
      present(1, 1, 0);
      tick(1, 0, -1, -1, 0); tick(1, 0, -1, -1, 0);
      idle();
      tick(0, 0, -1, -1, 1);
      auto_ret = 1'b1;
      drain(8);

      // Flush, then the same sequence with reset.
      for (int pass = 0; pass < 2; pass++) begin
         present(0, 5, 9);
         tick(1);
         present(1, 6, 10);
         tick(1);
         present(0, 1, 0, 9, 1);
         if (pass == 0) flush = 1'b1; else rst = 1'b1;
         tick(0, 1);
         flush = 1'b0; rst = 1'b0;
         tick(1, 0, 1, 0);
         drain(4);
      end

      // Random traffic.
      auto_ret = 1'b0;
      age = 0;
      idle();
      for (int n = 0; n < 1500; n++) begin
         if (!valid || m_issue || age > 12) begin
            age = 0;
            valid  = ($urandom_range(0, 3) != 0);
            unit   = 4'b0001 << $urandom_range(0, 3);
            lat    = 4'($urandom_range(0, 8));
            src[0] = 5'($urandom_range(0, 7));
            src[1] = 5'($urandom_range(0, 7));
            srcv   = 2'($urandom_range(0, 3));
            dest   = 5'($urandom_range(0, 7));
            fence  = ($urandom_range(0, 19) == 0);
         end else age++;
         dstall = ($urandom_range(0, 9) == 0);
         flush  = ($urandom_range(0, 99) == 0);
         rst    = ($urandom_range(0, 199) == 0);
         retire = (m_occ > 0) && ($urandom_range(0, 1) == 1);
         tick();
      end
      idle();
      retire = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
